// File: rtl/uart_tx_arbiter_if.sv
// Byte-source handshakes and the txmit write interface shared by uart_tx_arbiter.
// The master modport is the arbiter; slave is the surrounding sources and transmitter.
interface uart_tx_arbiter_if;
  logic       d0_valid;
  logic [7:0] d0_data;
  logic       d0_ready;
  logic       d1_valid;
  logic [7:0] d1_data;
  logic       d1_ready;
  logic       tbre;
  logic [7:0] tdin;
  logic       wrn;

  modport master (
    input  d0_valid, d0_data, d1_valid, d1_data, tbre,
    output d0_ready, d1_ready, tdin, wrn
  );

  modport slave (
    output d0_valid, d0_data, d1_valid, d1_data, tbre,
    input  d0_ready, d1_ready, tdin, wrn
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the txmit transmitter between two byte sources,
// sequencing each tdin/wrn write against the synchronized tbre flag.
module uart_tx_arbiter #(
  parameter int          WRN_LOW = 6000,
  parameter int          SETUP   = 4,
  parameter logic [15:0] TIMEOUT = 16'd65535
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_arbiter_if.master  bus,
  output logic               busy,
  output logic               tx_err,
  output logic [15:0]        tx_count,
  output logic               last_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  localparam logic [15:0] SETUP_LAST   = 16'(SETUP - 1);
  localparam logic [15:0] STROBE_LAST  = 16'(WRN_LOW - 1);
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  tbre_sync;
  logic        tbre_s;
  logic        grant;
  logic        grant_ch;

  assign tbre_s = tbre_sync[1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant    = 1'b0;
    grant_ch = 1'b0;
    if (tbre_s) begin
      if (bus.d0_valid && bus.d1_valid) begin
        grant    = 1'b1;
        grant_ch = ~last_ch;
      end else if (bus.d0_valid) begin
        grant    = 1'b1;
        grant_ch = 1'b0;
      end else if (bus.d1_valid) begin
        grant    = 1'b1;
        grant_ch = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // lets a mid-strobe reset release wrn without waiting for a clock edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tbre_sync    <= 2'b11;
      bus.tdin     <= '0;
      bus.wrn      <= 1'b1;
      bus.d0_ready <= 1'b0;
      bus.d1_ready <= 1'b0;
      busy         <= 1'b0;
      tx_err       <= 1'b0;
      tx_count     <= '0;
      last_ch      <= 1'b1;
    end else begin
      tbre_sync    <= {tbre_sync[0], bus.tbre};
      bus.d0_ready <= 1'b0;
      bus.d1_ready <= 1'b0;
      cnt          <= cnt + 16'd1;
      case (state)
        S_IDLE: begin
          if (grant) begin
            bus.tdin     <= grant_ch ? bus.d1_data : bus.d0_data;
            bus.d0_ready <= ~grant_ch;
            bus.d1_ready <= grant_ch;
            last_ch      <= grant_ch;
            state        <= S_SETUP;
            busy         <= 1'b1;
            cnt          <= '0;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            bus.wrn <= 1'b0;
            state   <= S_STROBE;
            cnt     <= '0;
          end
        end
        S_STROBE: begin
          if (cnt == STROBE_LAST) begin
            bus.wrn <= 1'b1;
            state   <= S_HOLD;
            cnt     <= '0;
          end
        end
        S_HOLD: begin
          // tbre activity here is deliberately ignored; only WAIT_BUSY sees the fall.
          if (cnt == SETUP_LAST) begin
            state <= S_WAIT_BUSY;
            cnt   <= '0;
          end
        end
        S_WAIT_BUSY: begin
          if (!tbre_s) begin
            state <= S_WAIT_DONE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            tx_err <= 1'b1;
            state  <= S_IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
          end
        end
        S_WAIT_DONE: begin
          if (tbre_s) begin
            tx_count <= tx_count + 16'd1;
            state    <= S_IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            tx_err <= 1'b1;
            state  <= S_IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
          end
        end
        default: begin
          bus.wrn <= 1'b1;
          state   <= S_IDLE;
          busy    <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a scaled-down txmit tbre model
// (clk16x = 2 CLK, so 3 clk16x = 6 CLK and 10 bit times = 320 CLK).
module tb_uart_tx_arbiter;

  localparam int          WRN_LOW_TB = 20;
  localparam int          SETUP_TB   = 4;
  localparam logic [15:0] TIMEOUT_TB = 16'd1000;
  localparam int          DROP_CYC   = 6;
  localparam int          BUSY_CYC   = 320;

  logic        CLK;
  logic        RST;
  logic        busy;
  logic        tx_err;
  logic [15:0] tx_count;
  logic        last_ch;
  logic        tbre_model;
  logic        tbre_gate;
  logic        tbre_auto;
  int          total;
  int          bad;

  uart_tx_arbiter_if bus ();

  assign bus.tbre = tbre_model & tbre_gate;

  uart_tx_arbiter #(
    .WRN_LOW (WRN_LOW_TB),
    .SETUP   (SETUP_TB),
    .TIMEOUT (TIMEOUT_TB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .busy     (busy),
    .tx_err   (tx_err),
    .tx_count (tx_count),
    .last_ch  (last_ch)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Transmitter model: buffer goes busy shortly after each write and empties a frame later.
  initial begin
    tbre_model = 1'b1;
    forever begin
      @(posedge bus.wrn);
      if (tbre_auto) begin
        repeat (DROP_CYC) @(posedge CLK);
        #1 tbre_model = 1'b0;
        repeat (BUSY_CYC) @(posedge CLK);
        #1 tbre_model = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    total++; if (bus.wrn !== 1'b1) begin bad++; $display("FAIL reset_wrn: got %b want 1", bus.wrn); end
    total++; if (bus.tdin !== 8'h00) begin bad++; $display("FAIL reset_tdin: got %h want 00", bus.tdin); end
    total++; if ({bus.d0_ready, bus.d1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {bus.d0_ready, bus.d1_ready}); end
    total++; if ({busy, tx_err} !== 2'b00) begin bad++; $display("FAIL reset_busy_err: got %b want 00", {busy, tx_err}); end
    total++; if (tx_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", tx_count); end
    total++; if (last_ch !== 1'b1) begin bad++; $display("FAIL reset_last_ch: got %b want 1", last_ch); end
    RST = 1'b1;
  endtask

  task automatic test_single;
    int pulses, other, wrn_low, tdin_bad, rise_c, done_c;
    logic prev_tbre, started;
    pulses = 0; other = 0; wrn_low = 0; tdin_bad = 0; rise_c = -1; done_c = -1;
    prev_tbre = 1'b1; started = 1'b0;
    tbre_auto = 1'b1;
    @(negedge CLK);
    bus.d0_data  = 8'hA5;
    bus.d0_valid = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (bus.d0_ready) begin pulses++; bus.d0_valid = 1'b0; bus.d0_data = 8'h00; end
      if (bus.d1_ready) other++;
      if (!bus.wrn) begin wrn_low++; if (bus.tdin !== 8'hA5) tdin_bad++; end
      if (busy) started = 1'b1;
      if (started && !prev_tbre && bus.tbre) rise_c = c;
      prev_tbre = bus.tbre;
      if (started && !busy) begin done_c = c; break; end
    end
    total++; if (done_c < 0) begin bad++; $display("FAIL single_done: busy never fell, required within 3000 cycles"); end
    total++; if (pulses != 1) begin bad++; $display("FAIL single_d0_ready: got %0d pulses want 1", pulses); end
    total++; if (other != 0) begin bad++; $display("FAIL single_d1_ready: got %0d pulses want 0", other); end
    total++; if (wrn_low != WRN_LOW_TB) begin bad++; $display("FAIL single_wrn_low: got %0d cycles want %0d", wrn_low, WRN_LOW_TB); end
    total++; if (tdin_bad != 0) begin bad++; $display("FAIL single_tdin: got %0d bad strobe cycles want 0", tdin_bad); end
    total++; if (tx_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", tx_count); end
    total++; if (done_c - rise_c != 3) begin bad++; $display("FAIL single_busy_fall: got %0d cycles after tbre rise want 3", done_c - rise_c); end
    total++; if (last_ch !== 1'b0) begin bad++; $display("FAIL single_last_ch: got %b want 0", last_ch); end
  endtask

  task automatic test_contention;
    int n, overlap;
    int ch[4];
    logic [7:0] td[4];
    logic prev_busy, done;
    n = 0; overlap = 0; prev_busy = 1'b0; done = 1'b0;
    apply_reset();
    tbre_auto = 1'b1;
    @(negedge CLK);
    bus.d0_data = 8'h11; bus.d1_data = 8'h22;
    bus.d0_valid = 1'b1; bus.d1_valid = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      @(negedge CLK);
      if (bus.d0_ready || bus.d1_ready) begin
        if (prev_busy) overlap++;
        if (n < 4) begin ch[n] = bus.d1_ready ? 1 : 0; td[n] = bus.tdin; end
        n++;
      end
      prev_busy = busy;
      if (n >= 4 && !busy) begin
        done = 1'b1; bus.d0_valid = 1'b0; bus.d1_valid = 1'b0;
        break;
      end
    end
    bus.d0_valid = 1'b0; bus.d1_valid = 1'b0;
    total++; if (!done || n != 4) begin bad++; $display("FAIL contention_grants: got %0d grants (done=%b) want 4", n, done); end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        total++; if (ch[i] != i % 2) begin bad++; $display("FAIL contention_order[%0d]: got ch%0d want ch%0d", i, ch[i], i % 2); end
        total++; if (td[i] !== ((i % 2) ? 8'h22 : 8'h11)) begin bad++; $display("FAIL contention_tdin[%0d]: got %h want %h", i, td[i], (i % 2) ? 8'h22 : 8'h11); end
      end
    end
    total++; if (overlap != 0) begin bad++; $display("FAIL contention_overlap: got %0d ready pulses while busy want 0", overlap); end
    total++; if (tx_count !== 16'd4) begin bad++; $display("FAIL contention_count: got %0d want 4", tx_count); end
  endtask

  task automatic test_stuck;
    int rise_c, done_c, gnt_c;
    logic prev_wrn, granted;
    logic [7:0] gnt_tdin;
    rise_c = -1; done_c = -1; gnt_c = -1; prev_wrn = 1'b1; granted = 1'b0; gnt_tdin = 8'h00;
    apply_reset();
    tbre_auto = 1'b0;
    @(negedge CLK);
    bus.d0_data = 8'h5A; bus.d0_valid = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (bus.d0_ready) begin granted = 1'b1; bus.d0_valid = 1'b0; end
      if (granted && !prev_wrn && bus.wrn) rise_c = c;
      prev_wrn = bus.wrn;
      if (granted && !busy) begin done_c = c; break; end
    end
    total++; if (done_c < 0 || rise_c < 0) begin bad++; $display("FAIL stuck_done: write never ended (rise=%0d done=%0d)", rise_c, done_c); end
    total++; if (done_c - rise_c != SETUP_TB + int'(TIMEOUT_TB)) begin bad++; $display("FAIL stuck_timeout: got %0d cycles after wrn rise want %0d", done_c - rise_c, SETUP_TB + int'(TIMEOUT_TB)); end
    total++; if ({tx_err, busy} !== 2'b10) begin bad++; $display("FAIL stuck_flags: got err,busy=%b want 10", {tx_err, busy}); end
    total++; if (tx_count !== 16'd0) begin bad++; $display("FAIL stuck_count: got %0d want 0", tx_count); end
    // A later request must still be served after the fault.
    tbre_auto = 1'b1;
    granted = 1'b0; done_c = -1;
    bus.d1_data = 8'h3C; bus.d1_valid = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      if (bus.d1_ready) begin granted = 1'b1; gnt_c = c; gnt_tdin = bus.tdin; bus.d1_valid = 1'b0; end
      if (granted && !busy) begin done_c = c; break; end
    end
    bus.d1_valid = 1'b0;
    total++; if (gnt_c < 0 || gnt_tdin !== 8'h3C) begin bad++; $display("FAIL stuck_regrant: got granted=%b tdin=%h want 1 3c", granted, gnt_tdin); end
    total++; if (done_c < 0 || tx_count !== 16'd1) begin bad++; $display("FAIL stuck_regrant_count: got %0d want 1", tx_count); end
    total++; if (tx_err !== 1'b1) begin bad++; $display("FAIL stuck_sticky_err: got %b want 1", tx_err); end
  endtask

  task automatic test_not_ready;
    int stray, k, done_c;
    stray = 0; k = -1; done_c = -1;
    tbre_auto = 1'b1;
    @(negedge CLK);
    tbre_gate = 1'b0;
    repeat (4) @(negedge CLK);
    bus.d0_data = 8'h77; bus.d0_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (bus.d0_ready || !bus.wrn || busy) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL not_ready_hold: got %0d active cycles want 0", stray); end
    tbre_gate = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (bus.d0_ready) begin k = c; bus.d0_valid = 1'b0; break; end
    end
    bus.d0_valid = 1'b0;
    total++; if (!(k == 2 || k == 3)) begin bad++; $display("FAIL not_ready_latency: got %0d cycles want 2..3", k); end
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      if (!busy) begin done_c = c; break; end
    end
    total++; if (done_c < 0 || tx_count !== 16'd2) begin bad++; $display("FAIL not_ready_count: got %0d want 2", tx_count); end
    total++; if (bus.tdin !== 8'h77) begin bad++; $display("FAIL not_ready_tdin: got %h want 77", bus.tdin); end
  endtask

  task automatic test_reset_strobe;
    logic seen;
    seen = 1'b0;
    tbre_auto = 1'b0;
    @(negedge CLK);
    bus.d0_data = 8'h99; bus.d0_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (bus.d0_ready) bus.d0_valid = 1'b0;
      if (!bus.wrn) begin seen = 1'b1; break; end
    end
    bus.d0_valid = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL rst_strobe_reach: wrn never fell, required within 100 cycles"); end
    repeat (5) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    total++; if (bus.wrn !== 1'b1) begin bad++; $display("FAIL rst_strobe_wrn: got %b want 1", bus.wrn); end
    total++; if ({busy, tx_err} !== 2'b00) begin bad++; $display("FAIL rst_strobe_flags: got busy,err=%b want 00", {busy, tx_err}); end
    total++; if (tx_count !== 16'd0) begin bad++; $display("FAIL rst_strobe_count: got %0d want 0", tx_count); end
    @(negedge CLK);
    RST = 1'b1;
    tbre_auto = 1'b1;
  endtask

  task automatic test_wrap;
    int done_c;
    logic granted;
    done_c = -1; granted = 1'b0;
    @(negedge CLK);
    force dut.tx_count = 16'hFFFF;
    @(negedge CLK);
    release dut.tx_count;
    bus.d1_data = 8'hE7; bus.d1_valid = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      if (bus.d1_ready) begin granted = 1'b1; bus.d1_valid = 1'b0; end
      if (granted && !busy) begin done_c = c; break; end
    end
    bus.d1_valid = 1'b0;
    total++; if (done_c < 0) begin bad++; $display("FAIL wrap_done: write never ended, required within 1000 cycles"); end
    total++; if (tx_count !== 16'd0) begin bad++; $display("FAIL wrap_count: got %0d want 0", tx_count); end
    total++; if (last_ch !== 1'b1) begin bad++; $display("FAIL wrap_last_ch: got %b want 1", last_ch); end
  endtask

  initial begin
    total = 0; bad = 0;
    RST = 1'b0;
    tbre_gate = 1'b1; tbre_auto = 1'b0;
    bus.d0_valid = 1'b0; bus.d0_data = 8'h00;
    bus.d1_valid = 1'b0; bus.d1_data = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_stuck();
    test_not_ready();
    test_reset_strobe();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
